ram_arbiter: RTL and testbench

- Shares the single data RAM (8-bit address, 8-bit data, synchronous write port, asynchronous read port behind an output-enable transceiver) between two requesters.
- Requester 0 is the CPU memory stage; requester 1 is the debug/loader port.
- Serializes one access at a time through a 3-state FSM, arbitrates round-robin (or fixed priority), and returns registered read data with a valid pulse.

---
 rtl/ram_arbiter_if.sv | 53 +++++
 rtl/ram_arbiter.sv | 114 +++++++++++
 tb/tb_ram_arbiter.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM requesters, the arbiter and the shared data RAM.
// The master side is the requester/RAM environment; the slave side is the arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  req0;
  logic                  we0;
  logic [ADDR_WIDTH-1:0] addr0;
  logic [DATA_WIDTH-1:0] wdata0;
  logic                  gnt0;
  logic                  rvalid0;
  logic [DATA_WIDTH-1:0] rdata0;

  logic                  req1;
  logic                  we1;
  logic [ADDR_WIDTH-1:0] addr1;
  logic [DATA_WIDTH-1:0] wdata1;
  logic                  gnt1;
  logic                  rvalid1;
  logic [DATA_WIDTH-1:0] rdata1;

  logic                  busy;

  logic [ADDR_WIDTH-1:0] ram_write_addr;
  logic [DATA_WIDTH-1:0] ram_write_data;
  logic                  ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_read_addr;
  logic [DATA_WIDTH-1:0] ram_read_data;
  logic                  ram_out_en;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_read_data,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output busy,
    output ram_write_addr, ram_write_data, ram_write_en,
    output ram_read_addr, ram_out_en
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_read_data,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  busy,
    input  ram_write_addr, ram_write_data, ram_write_en,
    input  ram_read_addr, ram_out_en
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the shared data RAM: one access at a time,
// round-robin or fixed priority, registered read data with a valid pulse.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | sampling requests; a winner is latched on the edge leaving IDLE
// ACCESS  | gnt pulse; RAM write strobe or output enable for latched access
// RESPOND | read data registered; rvalid pulse to the winner
module ram_arbiter #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input logic          clk,
  input logic          rst,
  ram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  take, take_sel;
  logic                  last_gnt, winner, lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic                  gnt0_q, gnt1_q, rvalid0_q, rvalid1_q, busy_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    take_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          take = 1'b1;
          // On a conflict round-robin favours whoever was not served last
          if (bus.req0 && bus.req1) take_sel = FIXED_PRIORITY ? 1'b0 : ~last_gnt;
          else                      take_sel = bus.req1;
          state_next = ACCESS;
        end
      end
      ACCESS:  state_next = lat_we ? IDLE : RESPOND;
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt  <= 1'b1;
      winner    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      busy_q    <= (state_next != IDLE);
      if (take) begin
        winner    <= take_sel;
        last_gnt  <= take_sel;
        lat_we    <= take_sel ? bus.we1    : bus.we0;
        lat_addr  <= take_sel ? bus.addr1  : bus.addr0;
        lat_wdata <= take_sel ? bus.wdata1 : bus.wdata0;
        gnt0_q    <= ~take_sel;
        gnt1_q    <= take_sel;
      end
      if (state == ACCESS && !lat_we) begin
        if (winner) begin
          rdata1_q  <= bus.ram_read_data;
          rvalid1_q <= 1'b1;
        end else begin
          rdata0_q  <= bus.ram_read_data;
          rvalid0_q <= 1'b1;
        end
      end
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;
  assign bus.busy    = busy_q;

  // RAM strobes decode straight from state so a reset drops them without waiting for a clock
  assign bus.ram_write_addr = lat_addr;
  assign bus.ram_read_addr  = lat_addr;
  assign bus.ram_write_data = lat_wdata;
  assign bus.ram_write_en   = (state == ACCESS) && lat_we;
  assign bus.ram_out_en     = (state == ACCESS) && !lat_we;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: round-robin and fixed-priority instances share stimulus,
// each with its own RAM and a transaction-level reference model.
module tb_ram_arbiter;
  localparam int AW = 8;
  localparam int DW = 8;

  logic clk, rst, ram_load;
  logic r0, w0, r1, w1;
  logic [7:0] a0, d0, a1, d1;

  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_rr ();
  ram_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_fp ();

  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b0)) dut_rr (
    .clk(clk), .rst(rst), .bus(bus_rr.slave));
  ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .bus(bus_fp.slave));

  assign {bus_rr.req0, bus_rr.we0, bus_rr.addr0, bus_rr.wdata0,
          bus_rr.req1, bus_rr.we1, bus_rr.addr1, bus_rr.wdata1} = {r0, w0, a0, d0, r1, w1, a1, d1};
  assign {bus_fp.req0, bus_fp.we0, bus_fp.addr0, bus_fp.wdata0,
          bus_fp.req1, bus_fp.we1, bus_fp.addr1, bus_fp.wdata1} = {r0, w0, a0, d0, r1, w1, a1, d1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Physical RAMs attached to each DUT: synchronous write, asynchronous read behind OE
  logic [7:0] ram [2][256];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 256; i++) begin
        ram[0][i] <= 8'(i) ^ 8'h5A;
        ram[1][i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      if (bus_rr.ram_write_en) ram[0][bus_rr.ram_write_addr] <= bus_rr.ram_write_data;
      if (bus_fp.ram_write_en) ram[1][bus_fp.ram_write_addr] <= bus_fp.ram_write_data;
    end
  end
  assign bus_rr.ram_read_data = bus_rr.ram_out_en ? ram[0][bus_rr.ram_read_addr] : 8'h00;
  assign bus_fp.ram_read_data = bus_fp.ram_out_en ? ram[1][bus_fp.ram_read_addr] : 8'h00;

  // flags = {gnt0, gnt1, rvalid0, rvalid1, busy, ram_write_en, ram_out_en}
  logic [6:0] a_flags [2];
  logic [7:0] a_rd0 [2], a_rd1 [2], a_wa [2], a_wd [2], a_ra [2];
  assign a_flags[0] = {bus_rr.gnt0, bus_rr.gnt1, bus_rr.rvalid0, bus_rr.rvalid1,
                       bus_rr.busy, bus_rr.ram_write_en, bus_rr.ram_out_en};
  assign a_flags[1] = {bus_fp.gnt0, bus_fp.gnt1, bus_fp.rvalid0, bus_fp.rvalid1,
                       bus_fp.busy, bus_fp.ram_write_en, bus_fp.ram_out_en};
  assign a_rd0[0] = bus_rr.rdata0;          assign a_rd0[1] = bus_fp.rdata0;
  assign a_rd1[0] = bus_rr.rdata1;          assign a_rd1[1] = bus_fp.rdata1;
  assign a_wa[0]  = bus_rr.ram_write_addr;  assign a_wa[1]  = bus_fp.ram_write_addr;
  assign a_wd[0]  = bus_rr.ram_write_data;  assign a_wd[1]  = bus_fp.ram_write_data;
  assign a_ra[0]  = bus_rr.ram_read_addr;   assign a_ra[1]  = bus_fp.ram_read_addr;

  // Reference model: one outstanding access described by its start cycle and contents
  logic [7:0] m_mem [2][256];
  logic       m_active [2], m_last [2], m_who [2], m_we [2];
  logic [7:0] m_addr [2], m_wdata [2], m_rd0 [2], m_rd1 [2];
  int         m_start [2];
  int         cyc;
  int         vectors, miscompares;

  task automatic chk(string name, int d, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d cycle %0d: got %h want %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic sb_step();
    logic acc, rsp, ew, eo, who;
    logic [6:0] ef;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_active[d] = 1'b0;
        m_last[d]   = 1'b1;
        m_rd0[d]    = 8'h00;
        m_rd1[d]    = 8'h00;
      end else begin
        acc = m_active[d] && (cyc == m_start[d] + 1);
        rsp = m_active[d] && !m_we[d] && (cyc == m_start[d] + 2);
        if (rsp) begin
          if (m_who[d]) m_rd1[d] = m_mem[d][m_addr[d]];
          else          m_rd0[d] = m_mem[d][m_addr[d]];
        end
        ew = acc && m_we[d];
        eo = acc && !m_we[d];
        ef = {acc && !m_who[d], acc && m_who[d], rsp && !m_who[d], rsp && m_who[d], acc || rsp, ew, eo};
        chk("flags", d, 16'(a_flags[d]), 16'(ef));
        chk("rdata0", d, 16'(a_rd0[d]), 16'(m_rd0[d]));
        chk("rdata1", d, 16'(a_rd1[d]), 16'(m_rd1[d]));
        if (ew) begin
          chk("wr_port", d, {a_wa[d], a_wd[d]}, {m_addr[d], m_wdata[d]});
          m_mem[d][m_addr[d]] = m_wdata[d];
        end
        if (eo) chk("rd_addr", d, 16'(a_ra[d]), 16'(m_addr[d]));
        if (m_active[d] && (cyc >= m_start[d] + (m_we[d] ? 2 : 3))) m_active[d] = 1'b0;
        if (!m_active[d] && (r0 || r1)) begin
          if (r0 && r1) who = (d == 1) ? 1'b0 : !m_last[d];
          else          who = r1;
          m_who[d]    = who;
          m_last[d]   = who;
          m_active[d] = 1'b1;
          m_start[d]  = cyc;
          m_we[d]     = who ? w1 : w0;
          m_addr[d]   = who ? a1 : a0;
          m_wdata[d]  = who ? d1 : d0;
        end
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {r0, w0, a0, d0, r1, w1, a1, d1} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [7:0] pick_addr();
    int v;
    v = $urandom_range(0, 8);
    return (v == 8) ? 8'hFF : 8'(v);
  endfunction

  typedef struct {
    logic       r0, w0;
    logic [7:0] a0, d0;
    logic       r1, w1;
    logic [7:0] a1, d1;
    logic [6:0] flags;
    logic [7:0] rd0, rd1;
  } vec_t;
  vec_t tbl [14];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000110, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 7'b0000000, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h00, 7'b0100101, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0001100, 8'h00, 8'hA5};
    tbl[5]  = '{1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'hA5};
    tbl[6]  = '{1'b1, 1'b1, 8'hFF, 8'h3C, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000110, 8'h00, 8'hA5};
    tbl[7]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'h00, 8'hA5};
    tbl[8]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000101, 8'h00, 8'hA5};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'h3C, 8'hA5};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'h3C, 8'hA5};
    tbl[11] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b1000101, 8'h3C, 8'hA5};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0010100, 8'h5A, 8'hA5};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 7'b0000000, 8'h5A, 8'hA5};

    vectors = 0;
    miscompares = 0;
    cyc = 0;
    rst = 1'b1;
    ram_load = 1'b1;
    idle_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 256; i++) m_mem[d][i] = 8'(i) ^ 8'h5A;
    @(posedge clk);
    #1;
    step();
    step();
    ram_load = 1'b0;
    rst = 1'b0;
    step();
    for (int d = 0; d < 2; d++)
      chk("reset_ram_side", d, {a_wa[d], a_wd[d] | a_ra[d]}, 16'h0000);

    // Directed write / cross-requester read / 0xFF and 0x00 readback
    for (int k = 0; k < 14; k++) begin
      {r0, w0, a0, d0, r1, w1, a1, d1} =
        {tbl[k].r0, tbl[k].w0, tbl[k].a0, tbl[k].d0, tbl[k].r1, tbl[k].w1, tbl[k].a1, tbl[k].d1};
      @(negedge clk);
      sb_step();
      chk("tbl_flags", 0, 16'(a_flags[0]), 16'(tbl[k].flags));
      chk("tbl_rdata", 0, {a_rd0[0], a_rd1[0]}, {tbl[k].rd0, tbl[k].rd1});
      @(posedge clk);
      #1;
    end

    // Both requesters hold reads: alternation vs. fixed priority, then req0 drops
    do_reset();
    for (int c = 0; c < 15; c++) begin
      r0 = (c < 12); w0 = 1'b0; a0 = 8'h01; d0 = 8'h00;
      r1 = (c < 14); w1 = 1'b0; a1 = 8'h02; d1 = 8'h00;
      @(negedge clk);
      sb_step();
      chk("rr_gnt", 0, 16'({a_flags[0][6], a_flags[0][5]}),
          16'({c == 1 || c == 7, c == 4 || c == 10 || c == 13}));
      chk("fp_gnt", 1, 16'({a_flags[1][6], a_flags[1][5]}),
          16'({c == 1 || c == 4 || c == 7 || c == 10, c == 13}));
      @(posedge clk);
      #1;
    end
    idle_inputs();
    step();
    step();

    // Reset asserted in the ACCESS cycle of a write to 0x20
    r0 = 1'b1; w0 = 1'b1; a0 = 8'h20; d0 = 8'h77;
    step();
    chk("pre_abort_we", 0, 16'(a_flags[0][1]), 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) chk("abort_flags", d, 16'(a_flags[d]), 16'h0000);
    idle_inputs();
    @(negedge clk);
    sb_step();
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    step();
    r1 = 1'b1; w1 = 1'b0; a1 = 8'h20;
    step();
    r1 = 1'b0;
    step();
    step();
    chk("abort_readback", 0, 16'(a_rd1[0]), 16'h007A);

    // Random traffic against the reference model
    for (int k = 0; k < 600; k++) begin
      r0 = ($urandom_range(0, 9) < 6);
      w0 = 1'($urandom_range(0, 1));
      a0 = pick_addr();
      d0 = 8'($urandom);
      r1 = ($urandom_range(0, 9) < 6);
      w1 = 1'($urandom_range(0, 1));
      a1 = pick_addr();
      d1 = 8'($urandom);
      step();
    end
    idle_inputs();
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
